// File: rtl/data_ram_pkg.sv
// Shared encodings and helpers for the data-memory responder.
// DATA_RAM_DWORD_EN adds the doubleword (RESP2) access path.
package data_ram_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
`ifdef DATA_RAM_DWORD_EN
    localparam logic [1:0] ST_RESP2 = 2'd3;
`endif

    // Alignment check only; whether doubleword is supported at all is decided by the caller.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr);
        case (size)
            SIZE_HALF:  return addr[0];
            SIZE_WORD:  return |addr[1:0];
            SIZE_DWORD: return |addr;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// Four byte-lane memories with per-lane write enables and an asynchronous word read.
// DATA_RAM_DWORD_EN adds a second full-word write port for doubleword stores.
module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int WORDS = 128
) (
    input  logic                       clk,
    input  logic [3:0]                 lane_we,
    input  logic [$clog2(WORDS)-1:0]   waddr,
    input  logic [31:0]                wdata,
`ifdef DATA_RAM_DWORD_EN
    input  logic                       we2,
    input  logic [$clog2(WORDS)-1:0]   waddr2,
    input  logic [31:0]                wdata2,
`endif
    input  logic [$clog2(WORDS)-1:0]   raddr,
    output logic [31:0]                rdata
);

    // Lane l holds bits [8l+7:8l]; lane 3 is the byte at offset 00 (big-endian).
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [WORDS];

        always_ff @(posedge clk) begin
            if (lane_we[l]) mem[waddr] <= wdata[8*l +: 8];
`ifdef DATA_RAM_DWORD_EN
            if (we2) mem[waddr2] <= wdata2[8*l +: 8];
`endif
        end

        assign rdata[8*l +: 8] = mem[raddr];
    end

endmodule

// File: rtl/data_ram_responder.sv
// MEM-stage data RAM responder: request capture, wait states, lane steering and load extension.
// DATA_RAM_DWORD_EN enables doubleword accesses returned over two Ready pulses.
module data_ram_responder
    import data_ram_pkg::*;
#(
    parameter int DEPTH_BYTES = 512,
    parameter int WAIT_STATES = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           RAM_Enable,
    input  logic                           RAM_RW,
    input  logic                           RAM_SE,
    input  logic [1:0]                     RAM_Size,
    input  logic [$clog2(DEPTH_BYTES)-1:0] RAM_Address,
    input  logic [31:0]                    RAM_DataIn,
    output logic [31:0]                    RAM_DataOut,
    output logic                           RAM_Ready,
    output logic                           RAM_Error,
    output logic                           RAM_Busy
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;
    localparam int WW    = AW - 2;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    logic [1:0]    state;
    logic [3:0]    wait_cnt;
    logic          req_rw;
    logic          req_se;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic [31:0]   hold_q;
    logic [31:0]   rword;
    logic [31:0]   load_val;
    logic [31:0]   wdata;
    logic [3:0]    lane_we;
    logic [WW-1:0] word_addr;
    logic [WW-1:0] rd_addr;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic          req_err;
    logic          in_resp;
    logic          read_ok;
    logic          commit;

    assign word_addr = req_addr[AW-1:2];

`ifdef DATA_RAM_DWORD_EN
    logic [31:0] req_data2;
    logic        cap2;
    logic        is_dword;

    assign is_dword = (req_size == SIZE_DWORD);
    assign req_err  = misaligned(req_size, req_addr[2:0]);
    assign in_resp  = (state == ST_RESP) || (state == ST_RESP2);
    assign rd_addr  = (state == ST_RESP2) ? word_addr + WW'(1) : word_addr;
    assign commit   = (req_rw == RW_WRITE) && !req_err &&
                      (is_dword ? (state == ST_RESP2) : (state == ST_RESP));

    // Second store word arrives on the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap2 <= 1'b0;
        end else begin
            cap2 <= (state == ST_IDLE) && RAM_Enable;
            if (cap2) req_data2 <= RAM_DataIn;
        end
    end
`else
    assign req_err = misaligned(req_size, req_addr[2:0]) || (req_size == SIZE_DWORD);
    assign in_resp = (state == ST_RESP);
    assign rd_addr = word_addr;
    assign commit  = (state == ST_RESP) && (req_rw == RW_WRITE) && !req_err;
`endif

    assign read_ok     = in_resp && (req_rw == RW_READ) && !req_err;
    assign RAM_Ready   = in_resp;
    assign RAM_Error   = in_resp && req_err;
    assign RAM_Busy    = (state != ST_IDLE);
    assign RAM_DataOut = read_ok ? load_val : hold_q;

    always_comb begin
        wdata   = req_data;
        lane_we = 4'b0000;
        case (req_size)
            SIZE_BYTE: begin
                wdata   = {4{req_data[7:0]}};
                lane_we = 4'b1000 >> req_addr[1:0];
            end
            SIZE_HALF: begin
                wdata   = {2{req_data[15:0]}};
                lane_we = req_addr[1] ? 4'b0011 : 4'b1100;
            end
            default: lane_we = 4'b1111;
        endcase
        if (!commit) lane_we = 4'b0000;
    end

    always_comb begin
        case (req_addr[1:0])
            2'd1:    sel_byte = rword[23:16];
            2'd2:    sel_byte = rword[15:8];
            2'd3:    sel_byte = rword[7:0];
            default: sel_byte = rword[31:24];
        endcase
        sel_half = req_addr[1] ? rword[15:0] : rword[31:16];
        case (req_size)
            SIZE_BYTE: load_val = {{24{req_se & sel_byte[7]}}, sel_byte};
            SIZE_HALF: load_val = {{16{req_se & sel_half[15]}}, sel_half};
            default:   load_val = rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            hold_q   <= 32'd0;
        end else begin
            if (read_ok) hold_q <= load_val;
            case (state)
                ST_IDLE: begin
                    if (RAM_Enable) begin
                        req_rw   <= RAM_RW;
                        req_se   <= RAM_SE;
                        req_size <= RAM_Size;
                        req_addr <= RAM_Address;
                        req_data <= RAM_DataIn;
                        if (WS == 4'd0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WS;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) state <= ST_RESP;
                end
`ifdef DATA_RAM_DWORD_EN
                ST_RESP:  state <= (is_dword && !req_err) ? ST_RESP2 : ST_IDLE;
                ST_RESP2: state <= ST_IDLE;
`else
                ST_RESP:  state <= ST_IDLE;
`endif
                default:  state <= ST_IDLE;
            endcase
        end
    end

    data_ram_array #(.WORDS(WORDS)) u_array (
        .clk     (clk),
        .lane_we (lane_we),
        .waddr   (word_addr),
        .wdata   (wdata),
`ifdef DATA_RAM_DWORD_EN
        .we2     (commit && is_dword),
        .waddr2  (word_addr + WW'(1)),
        .wdata2  (req_data2),
`endif
        .raddr   (rd_addr),
        .rdata   (rword)
    );

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: byte-array reference model, per-cycle output compare,
// directed literal checks and randomized load/store traffic.
module tb_data_ram_responder;

    localparam int DEPTH = 512;
    localparam int WS    = 3;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          RAM_Enable = 1'b0;
    logic          RAM_RW = 1'b0;
    logic          RAM_SE = 1'b0;
    logic [1:0]    RAM_Size = 2'd0;
    logic [AW-1:0] RAM_Address = '0;
    logic [31:0]   RAM_DataIn = 32'd0;
    logic [31:0]   RAM_DataOut;
    logic          RAM_Ready;
    logic          RAM_Error;
    logic          RAM_Busy;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    data_ram_responder #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RAM_Enable  (RAM_Enable),
        .RAM_RW      (RAM_RW),
        .RAM_SE      (RAM_SE),
        .RAM_Size    (RAM_Size),
        .RAM_Address (RAM_Address),
        .RAM_DataIn  (RAM_DataIn),
        .RAM_DataOut (RAM_DataOut),
        .RAM_Ready   (RAM_Ready),
        .RAM_Error   (RAM_Error),
        .RAM_Busy    (RAM_Busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 500000ns");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    logic [7:0]    mdl_mem [DEPTH];
    int            busy_left = 0;
    logic          m_rw = 1'b0;
    logic          m_se = 1'b0;
    logic          m_err = 1'b0;
    logic [1:0]    m_size = 2'd0;
    logic [AW-1:0] m_addr = '0;
    logic [31:0]   m_data = 32'd0;
    logic [31:0]   m_load = 32'd0;
    logic [31:0]   m_hold = 32'd0;
    logic [31:0]   exp_q[$];

    function automatic logic mdl_err(input logic [1:0] sz, input int a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz == 2'd2) return (a % 4) != 0;
        if (sz == 2'd3) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [1:0] sz, input logic se, input int a);
        int v;
        if (sz == 2'd0) begin
            v = int'(mdl_mem[a]);
            if (se && v >= 128) v = v - 256;
            return 32'(v);
        end
        if (sz == 2'd1) begin
            v = int'(mdl_mem[a]) * 256 + int'(mdl_mem[a+1]);
            if (se && v >= 32768) v = v - 65536;
            return 32'(v);
        end
        return {mdl_mem[a], mdl_mem[a+1], mdl_mem[a+2], mdl_mem[a+3]};
    endfunction

    function automatic void mdl_write(input logic [1:0] sz, input int a, input logic [31:0] d);
        int n;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) mdl_mem[a+i] = 8'(d >> (8 * (n - 1 - i)));
    endfunction

    // A request occupies WS+1 cycles after acceptance; the last one is the response.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                busy_left = 0;
                m_hold = 32'd0;
                exp_q.delete();
            end else if (busy_left > 0) begin
                if (busy_left == 1 && !m_err) begin
                    if (m_rw) mdl_write(m_size, int'(m_addr), m_data);
                    else      m_hold = m_load;
                end
                busy_left--;
            end else if (RAM_Enable) begin
                m_rw   = RAM_RW;
                m_se   = RAM_SE;
                m_size = RAM_Size;
                m_addr = RAM_Address;
                m_data = RAM_DataIn;
                m_err  = mdl_err(m_size, int'(m_addr));
                m_load = (m_err || m_rw) ? 32'd0 : mdl_read(m_size, m_se, int'(m_addr));
                if (!m_rw && !m_err) exp_q.push_back(m_load);
                busy_left = WS + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy",  32'(RAM_Busy),  32'(busy_left > 0));
                check("ready", 32'(RAM_Ready), 32'(busy_left == 1));
                check("error", 32'(RAM_Error), 32'(busy_left == 1 && m_err));
                if (busy_left == 1 && !m_rw && !m_err) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL dout_q: got empty queue want pending load at %0t", $time);
                    end else begin
                        check("dout_load", RAM_DataOut, exp_q.pop_front());
                    end
                end else begin
                    check("dout_hold", RAM_DataOut, m_hold);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (RAM_Busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("idle_timeout", 32'(n), 32'd0);
    endtask

    task automatic xfer(input logic rw, input logic se, input logic [1:0] sz,
                        input logic [AW-1:0] a, input logic [31:0] d,
                        output logic [31:0] dout, output logic err, output int lat);
        wait_idle();
        RAM_Enable  = 1'b1;
        RAM_RW      = rw;
        RAM_SE      = se;
        RAM_Size    = sz;
        RAM_Address = a;
        RAM_DataIn  = d;
        @(negedge clk);
        RAM_Enable = 1'b0;
        lat = 1;
        while (!RAM_Ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) check("ready_timeout", 32'(lat), 32'(WS + 1));
        dout = RAM_DataOut;
        err  = RAM_Error;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        int          rp[$];

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_dout",  RAM_DataOut, 32'd0);
        check("rst_ready", 32'(RAM_Ready), 32'd0);
        check("rst_error", 32'(RAM_Error), 32'd0);
        check("rst_busy",  32'(RAM_Busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) xfer(1'b1, 1'b0, 2'd2, AW'(4 * i), $urandom, d, e, lat);
        xfer(1'b1, 1'b0, 2'd2, 9'h014, 32'h01234567, d, e, lat);
        xfer(1'b1, 1'b0, 2'd2, 9'h020, 32'hCAFEF00D, d, e, lat);

        xfer(1'b1, 1'b0, 2'd2, 9'h010, 32'hDEADBEEF, d, e, lat);
        check("wr_latency", 32'(lat), 32'(WS + 1));
        xfer(1'b0, 1'b0, 2'd2, 9'h010, 32'd0, d, e, lat);
        check("rd_latency", 32'(lat), 32'(WS + 1));
        check("rd_word", d, 32'hDEADBEEF);
        xfer(1'b0, 1'b1, 2'd0, 9'h010, 32'd0, d, e, lat);
        check("rd_byte_se", d, 32'hFFFFFFDE);
        xfer(1'b0, 1'b0, 2'd0, 9'h010, 32'd0, d, e, lat);
        check("rd_byte_ze", d, 32'h000000DE);
        xfer(1'b0, 1'b1, 2'd1, 9'h012, 32'd0, d, e, lat);
        check("rd_half_se", d, 32'hFFFFBEEF);

        xfer(1'b1, 1'b0, 2'd0, 9'h011, 32'h0000005A, d, e, lat);
        xfer(1'b0, 1'b0, 2'd2, 9'h010, 32'd0, d, e, lat);
        check("rd_after_byte_store", d, 32'hDE5ABEEF);

        xfer(1'b0, 1'b1, 2'd1, 9'h013, 32'd0, d, e, lat);
        check("half_misalign_err", 32'(e), 32'd1);
        check("half_misalign_dout", d, 32'hDE5ABEEF);
        xfer(1'b1, 1'b0, 2'd2, 9'h016, 32'hFFFFFFFF, d, e, lat);
        check("word_misalign_err", 32'(e), 32'd1);
        xfer(1'b0, 1'b0, 2'd2, 9'h014, 32'd0, d, e, lat);
        check("word_unchanged", d, 32'h01234567);
        xfer(1'b0, 1'b0, 2'd3, 9'h018, 32'd0, d, e, lat);
        check("dword_err", 32'(e), 32'd1);

        // Enable held high: accept, Ready WS+1 later, one idle cycle, accept again.
        wait_idle();
        RAM_Enable  = 1'b1;
        RAM_RW      = 1'b0;
        RAM_Size    = 2'd2;
        RAM_Address = 9'h010;
        for (int k = 1; k <= 3 * (WS + 2) - 1; k++) begin
            @(negedge clk);
            if (RAM_Ready) rp.push_back(k);
        end
        RAM_Enable = 1'b0;
        check("cont_pulses", 32'(rp.size()), 32'd3);
        if (rp.size() >= 2) begin
            check("cont_first", 32'(rp[0]), 32'd4);
            check("cont_second", 32'(rp[1]), 32'd9);
        end

        // Reset in the middle of a store's wait states.
        wait_idle();
        RAM_Enable  = 1'b1;
        RAM_RW      = 1'b1;
        RAM_Size    = 2'd2;
        RAM_Address = 9'h020;
        RAM_DataIn  = 32'h12345678;
        @(negedge clk);
        RAM_Enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(RAM_Ready), 32'd0);
        check("mid_rst_error", 32'(RAM_Error), 32'd0);
        check("mid_rst_busy",  32'(RAM_Busy), 32'd0);
        check("mid_rst_dout",  RAM_DataOut, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(1'b0, 1'b0, 2'd2, 9'h020, 32'd0, d, e, lat);
        check("aborted_write", d, 32'hCAFEF00D);

        for (int i = 0; i < 250; i++) begin
            xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 AW'($urandom_range(0, 63)), $urandom, d, e, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
